// File: rtl/clock_div_mc.sv
// clock_div_mc
//   N-channel fractional clock divider. Each channel divides local_clk by a
//   programmable integer half-period H. It can optionally stretch every S-th
//   half-period by one cycle, which gives an average period of 2H + 2/S.
//   New configuration and enable changes only take effect at glitch-free
//   boundaries.
//
// Ports
//   local_clk    in   source clock; all logic runs on its rising edge
//   rst          in   asynchronous active-low reset
//   ch_en        in   [NUM_CH]         per-channel run enable (level)
//   cfg_load     in   [NUM_CH]         1-cycle pulse: capture this channel's cfg slice
//   cfg_half     in   [NUM_CH*CNT_W]   half-period, channel i at [i*CNT_W +: CNT_W]
//   cfg_skip     in   [NUM_CH*SKIP_W]  stretch interval, channel i at [i*SKIP_W +: SKIP_W]
//   clk_out      out  [NUM_CH]         divided clocks (registered)
//   rise_stb     out  [NUM_CH]         high in the first cycle clk_out[i] is 1 after being 0
//   cfg_pending  out  [NUM_CH]         high while a captured config waits to become active
//   ch_state     out  [2*NUM_CH]       per-channel state, channel i at [2*i +: 2]
//                                      (0 idle, 1 run, 2 drain)
//
// Config protocol: cfg_load[i] has no back-pressure. Every pulse is accepted
// and overwrites the shadow registers. cfg_pending[i] rises on the cycle after
// the pulse. It falls on the cycle the shadow becomes active: either on the
// next 0->1 edge of clk_out[i], or one cycle later if the channel is idle.
module clock_div_mc #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int SKIP_W   = 6,
  parameter int DEF_HALF = 1,
  parameter int DEF_SKIP = 0
) (
  input  logic                       local_clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic [NUM_CH-1:0]          cfg_load,
  input  logic [NUM_CH*CNT_W-1:0]    cfg_half,
  input  logic [NUM_CH*SKIP_W-1:0]   cfg_skip,
  output logic [NUM_CH-1:0]          clk_out,
  output logic [NUM_CH-1:0]          rise_stb,
  output logic [NUM_CH-1:0]          cfg_pending,
  output logic [2*NUM_CH-1:0]        ch_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ch_state_e;

  localparam logic [CNT_W-1:0]  DEF_HALF_V = CNT_W'(DEF_HALF);
  localparam logic [SKIP_W-1:0] DEF_SKIP_V = SKIP_W'(DEF_SKIP);
  localparam logic [CNT_W-1:0]  ONE_H      = CNT_W'(1);
  localparam logic [SKIP_W-1:0] ONE_S      = SKIP_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e         state_q, state_d;
    logic [CNT_W-1:0]  half_q, half_d, act_half_q, act_half_d, sh_half_q, sh_half_d;
    logic [SKIP_W-1:0] skip_q, skip_d, act_skip_q, act_skip_d, sh_skip_q, sh_skip_d;
    logic              stretch_q, stretch_d, clk_q, clk_d, rise_q, rise_d, pend_q, pend_d;
    logic [CNT_W-1:0]  h_eff;
    logic              active, terminal, last_skip, toggle, rising, go_idle;

    always_comb begin
      // A programmed half-period of 0 behaves as 1.
      h_eff     = (act_half_q == '0) ? ONE_H : act_half_q;
      // An idle channel whose enable is seen starts counting in the same cycle.
      active    = (state_q != ST_IDLE) || ch_en[i];
      terminal  = active && !stretch_q && (half_q >= h_eff - ONE_H);
      last_skip = (act_skip_q != '0) && (skip_q >= act_skip_q - ONE_S);
      // stretch_q marks the single extra cycle inserted after a delayed terminal.
      toggle    = active && (stretch_q || (terminal && !last_skip));
      rising    = toggle && !clk_q;
      // Stop only at a falling toggle, or on a low cycle with no toggle.
      // This way a high phase is never cut short.
      go_idle   = active && !ch_en[i] && (clk_q ? toggle : !toggle);

      state_d    = state_q;
      half_d     = half_q;
      skip_d     = skip_q;
      stretch_d  = stretch_q;
      clk_d      = clk_q;
      rise_d     = 1'b0;
      pend_d     = pend_q;
      act_half_d = act_half_q;
      act_skip_d = act_skip_q;
      sh_half_d  = sh_half_q;
      sh_skip_d  = sh_skip_q;

      if (go_idle) begin
        state_d   = ST_IDLE;
        clk_d     = 1'b0;
        half_d    = '0;
        skip_d    = '0;
        stretch_d = 1'b0;
      end else if (active) begin
        state_d = ch_en[i] ? ST_RUN : ST_DRAIN;
        if (stretch_q) begin
          stretch_d = 1'b0;
          half_d    = '0;
          skip_d    = '0;
        end else if (terminal) begin
          if (last_skip) begin
            // Hold the counter at terminal for one more cycle; no wrap.
            stretch_d = 1'b1;
          end else begin
            half_d = '0;
            skip_d = (act_skip_q != '0) ? skip_q + ONE_S : '0;
          end
        end else begin
          half_d = half_q + ONE_H;
        end
        if (toggle) begin
          clk_d  = !clk_q;
          rise_d = !clk_q;
        end
        if (rising && pend_q) begin
          act_half_d = sh_half_q;
          act_skip_d = sh_skip_q;
          half_d     = '0;
          skip_d     = '0;
          pend_d     = 1'b0;
        end
      end else if (pend_q) begin
        // Idle channel with clk_out low: nothing to protect, so apply now.
        act_half_d = sh_half_q;
        act_skip_d = sh_skip_q;
        pend_d     = 1'b0;
      end

      // A load that coincides with an apply wins, so the newest value stays pending.
      if (cfg_load[i]) begin
        sh_half_d = cfg_half[i*CNT_W +: CNT_W];
        sh_skip_d = cfg_skip[i*SKIP_W +: SKIP_W];
        pend_d    = 1'b1;
      end
    end

    always_ff @(posedge local_clk or negedge rst) begin
      if (!rst) begin
        state_q    <= ST_IDLE;
        half_q     <= '0;
        skip_q     <= '0;
        stretch_q  <= 1'b0;
        clk_q      <= 1'b0;
        rise_q     <= 1'b0;
        pend_q     <= 1'b0;
        act_half_q <= DEF_HALF_V;
        act_skip_q <= DEF_SKIP_V;
        sh_half_q  <= DEF_HALF_V;
        sh_skip_q  <= DEF_SKIP_V;
      end else begin
        state_q    <= state_d;
        half_q     <= half_d;
        skip_q     <= skip_d;
        stretch_q  <= stretch_d;
        clk_q      <= clk_d;
        rise_q     <= rise_d;
        pend_q     <= pend_d;
        act_half_q <= act_half_d;
        act_skip_q <= act_skip_d;
        sh_half_q  <= sh_half_d;
        sh_skip_q  <= sh_skip_d;
      end
    end

    assign clk_out[i]        = clk_q;
    assign rise_stb[i]       = rise_q;
    assign cfg_pending[i]    = pend_q;
    assign ch_state[2*i +: 2] = state_q;
  end

endmodule

// File: tb/tb_clock_div_mc.sv
// tb_clock_div_mc
//   Directed bench for clock_div_mc. Stimulus tasks push the expected
//   half-period lengths of channel 0 into exp_q. A negedge monitor measures
//   every level of clk_out[0] and pops one expectation per change. The monitor
//   also checks on every channel that each rise_stb lines up with a 0->1 change
//   of clk_out.
module tb_clock_div_mc;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int SKIP_W = 6;

  logic                      local_clk;
  logic                      rst;
  logic [NUM_CH-1:0]         ch_en;
  logic [NUM_CH-1:0]         cfg_load;
  logic [NUM_CH*CNT_W-1:0]   cfg_half;
  logic [NUM_CH*SKIP_W-1:0]  cfg_skip;
  logic [NUM_CH-1:0]         clk_out;
  logic [NUM_CH-1:0]         rise_stb;
  logic [NUM_CH-1:0]         cfg_pending;
  logic [2*NUM_CH-1:0]       ch_state;

  clock_div_mc #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SKIP_W(SKIP_W), .DEF_HALF(1), .DEF_SKIP(0)
  ) dut (
    .local_clk  (local_clk),
    .rst        (rst),
    .ch_en      (ch_en),
    .cfg_load   (cfg_load),
    .cfg_half   (cfg_half),
    .cfg_skip   (cfg_skip),
    .clk_out    (clk_out),
    .rise_stb   (rise_stb),
    .cfg_pending(cfg_pending),
    .ch_state   (ch_state)
  );

  // ---------------- clock / reset ----------------
  initial local_clk = 1'b0;
  always #5 local_clk = ~local_clk;

  int cyc = 0;
  always @(posedge local_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_val;
  logic [NUM_CH-1:0] prev_clk = '0;
  int  last_chg = 0;
  bit  have_ref = 1'b0;
  bit  resync   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  always @(negedge local_clk) begin
    if (!rst) begin
      prev_clk = '0;
      have_ref = 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        check($sformatf("rise_stb_ch%0d", c), int'(rise_stb[c]),
              int'(clk_out[c] & ~prev_clk[c]));
      if (clk_out[0] != prev_clk[0]) begin
        if (resync) begin
          resync   = 1'b0;
          have_ref = 1'b1;
        end else if (have_ref && exp_q.size() > 0) begin
          exp_val = exp_q.pop_front();
          check("half_period_ch0", cyc - last_chg, int'(exp_val));
        end
        last_chg = cyc;
      end
      prev_clk = clk_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge local_clk);
    #1;
  endtask

  task automatic expect_halves(input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(v);
  endtask

  task automatic start_window();
    exp_q.delete();
    resync = 1'b1;
  endtask

  task automatic set_cfg(input int c, input int h, input int s);
    cfg_half[c*CNT_W +: CNT_W]   = CNT_W'(h);
    cfg_skip[c*SKIP_W +: SKIP_W] = SKIP_W'(s);
    cfg_load[c]                  = 1'b1;
  endtask

  task automatic wait_rise(input int c, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      tick();
      if (rise_stb[c]) seen = 1'b1;
    end
    if (!seen) timeout_fail(tag);
  endtask

  // Waits for the rising edge that should activate the shadow config.
  task automatic wait_apply(input int c, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      tick();
      if (rise_stb[c]) begin
        seen = 1'b1;
        check({tag, "_pend_clear"}, int'(cfg_pending[c]), 0);
      end
    end
    if (!seen) timeout_fail(tag);
  endtask

  task automatic wait_q_empty(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge local_clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail(tag);
      exp_q.delete();
    end
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b0;
    ch_en    = '1;
    cfg_load = '0;
    cfg_half = '0;
    cfg_skip = '0;
    repeat (3) @(posedge local_clk);
    #1;
    check("reset_clk_out", int'(clk_out), 0);
    check("reset_rise_stb", int'(rise_stb), 0);
    check("reset_pending", int'(cfg_pending), 0);

    // 1: defaults H=1,S=0, every level lasts one cycle
    rst = 1'b1;
    start_window();
    expect_halves(8'd1, 8);
    wait_q_empty("t1_defaults");
    check("t1_pending_low", int'(cfg_pending), 0);

    // 2: H=2,S=4 -> halves 2,2,2,3 repeating, pending clears on the apply rise
    wait_rise(0, "t2_sync");
    set_cfg(0, 2, 4);
    tick();
    cfg_load = '0;
    check("t2_pend_set", int'(cfg_pending[0]), 1);
    wait_apply(0, "t2_apply");
    start_window();
    expect_halves(8'd2, 3); expect_halves(8'd3, 1);
    expect_halves(8'd2, 3); expect_halves(8'd3, 1);
    wait_q_empty("t2_stretch");

    // 3: H=5 then H=3 before the next rise -> only H=3 applies
    wait_rise(0, "t3_sync");
    set_cfg(0, 5, 0);
    tick();
    set_cfg(0, 3, 0);
    tick();
    cfg_load = '0;
    check("t3_pend_set", int'(cfg_pending[0]), 1);
    wait_apply(0, "t3_apply");
    start_window();
    expect_halves(8'd3, 6);
    wait_q_empty("t3_last_wins");

    // 4: H=4, drop ch_en right after the apply rise -> high for 4 cycles total, then idle
    wait_rise(0, "t4_sync");
    set_cfg(0, 4, 0);
    tick();
    cfg_load = '0;
    wait_apply(0, "t4_apply");
    ch_en[0] = 1'b0;
    start_window();
    expect_halves(8'd4, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_high_kept", int'(clk_out[0]), 1);
    end
    tick();
    check("t4_fell", int'(clk_out[0]), 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t4_idle_clk", int'(clk_out[0]), 0);
      check("t4_idle_rise", int'(rise_stb[0]), 0);
    end
    wait_q_empty("t4_drain");

    // 6: load while idle (pending pulses one cycle), enable, then a load that
    //    coincides with a rising edge
    set_cfg(0, 2, 0);
    tick();
    cfg_load = '0;
    check("t6_idle_pend_set", int'(cfg_pending[0]), 1);
    tick();
    check("t6_idle_pend_pulse", int'(cfg_pending[0]), 0);
    ch_en[0] = 1'b1;
    tick();
    check("t6_en_first_low", int'(clk_out[0]), 0);
    tick();
    check("t6_en_first_rise", int'(clk_out[0]), 1);
    check("t6_en_first_stb", int'(rise_stb[0]), 1);
    start_window();
    expect_halves(8'd2, 4); expect_halves(8'd3, 4);
    repeat (3) tick();
    set_cfg(0, 3, 0);
    tick();
    cfg_load = '0;
    check("t6_coinc_rise", int'(rise_stb[0]), 1);
    check("t6_coinc_pend", int'(cfg_pending[0]), 1);
    wait_apply(0, "t6_apply");
    wait_q_empty("t6_coinc");

    // 5: reset while channel 2 stretches and channel 1 has a pending config
    set_cfg(2, 1, 1);
    tick();
    cfg_load = '0;
    repeat (6) tick();
    set_cfg(1, 7, 0);
    tick();
    cfg_load = '0;
    check("t5_pend_before_rst", int'(cfg_pending[1]), 1);
    #1 rst = 1'b0;
    #1;
    check("t5_rst_clk_out", int'(clk_out), 0);
    check("t5_rst_rise_stb", int'(rise_stb), 0);
    check("t5_rst_pending", int'(cfg_pending), 0);
    repeat (2) @(posedge local_clk);
    #1 rst = 1'b1;
    start_window();
    expect_halves(8'd1, 6);
    tick();
    check("t5_all_rise", int'(clk_out), 4'hF);
    check("t5_all_stb", int'(rise_stb), 4'hF);
    tick();
    check("t5_all_fall", int'(clk_out), 0);
    wait_q_empty("t5_defaults");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
